// File: rtl/seq_div_16_bit_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t            : FSM state encoding (IDLE, RUN, FIN)
//   DIV_WIDTH_DEFAULT  : default operand/result width
//   DBZ_QUOTIENT       : all-ones quotient reported on divide-by-zero.
//                        It is wide enough to be sliced down to any supported width.
package seq_div_16_bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_div_16_bit_if.sv
// Control-unit <-> divider handshake bundle.
//   start, dividend, divisor : request side (driven by the control unit)
//   busy, done               : progress/completion status
//   quotient, remainder      : results, held until the next operation finishes
//   div_by_zero              : set with done when the divisor was zero
// Modports:
//   master : the control unit issuing divides
//   slave  : the divider
interface seq_div_16_bit_if
  import seq_div_16_bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_div_16_bit_sub.sv
// sub_16_bit: combinational (WIDTH+1)-bit subtractor, diff = a - b.
// Implemented as a + ~b + 1; the carry out of the top bit is 1 exactly
// when a >= b, so it is exported directly as no_borrow.
//   a, b      : WIDTH+1-bit unsigned operands
//   diff      : a - b modulo 2**(WIDTH+1)
//   no_borrow : 1 when a >= b
module sub_16_bit
  import seq_div_16_bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
)
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           no_borrow
);

  logic [WIDTH+1:0] sum;

  assign sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+2)'(1);
  assign diff      = sum[WIDTH:0];
  assign no_borrow = sum[WIDTH+1];

endmodule

// File: rtl/seq_div_16_bit.sv
// seq_div_16_bit: multi-cycle unsigned restoring divider, one quotient bit
// per clock. A division takes WIDTH RUN cycles plus one FIN cycle; a zero
// divisor skips RUN and reports quotient = all ones, remainder = dividend.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset, aborts any operation in flight
//   bus   : slave side of seq_div_16_bit_if (start/busy/done handshake,
//           operands, quotient/remainder/div_by_zero results)
module seq_div_16_bit
  import seq_div_16_bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
)
(
  input  logic            clk,
  input  logic            rst_n,
  seq_div_16_bit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH:0]     r_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic [CNT_W-1:0]   count;
  logic               dbz_reg;

  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   rem_r;
  logic               dbz_r;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     trial;
  logic               sub_nb;
  logic               take;
  logic               accept;

  // Shift {R,Q} left by one: the top quotient bit moves into R.
  assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  sub_16_bit #(.WIDTH(WIDTH)) u_sub (
    .a         (r_shift),
    .b         ({1'b0, dvs_reg}),
    .diff      (trial),
    .no_borrow (sub_nb)
  );

  // A set bit shifted out of R means the shifted value exceeds any divisor,
  // so the subtraction always succeeds; the modulo difference is still exact.
  assign take = sub_nb | r_reg[WIDTH];

  // busy is low in IDLE and FIN, so a start is accepted in either state.
  assign accept = bus.start && ((state == IDLE) || (state == FIN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_reg   <= '0;
      q_reg   <= '0;
      dvs_reg <= '0;
      count   <= '0;
      dbz_reg <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;

      case (state)
        IDLE: ;

        RUN: begin
          r_reg <= take ? trial : r_shift;
          q_reg <= {q_reg[WIDTH-2:0], take};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state  <= FIN;
            busy_r <= 1'b0;
          end
        end

        FIN: begin
          done_r <= 1'b1;
          quot_r <= q_reg;
          rem_r  <= r_reg[WIDTH-1:0];
          dbz_r  <= dbz_reg;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // A start accepted in FIN overrides the return to IDLE; the results
      // above still latch the finishing operation's old register values.
      if (accept) begin
        dvs_reg <= bus.divisor;
        count   <= CNT_W'(WIDTH);
        if (bus.divisor != '0) begin
          r_reg   <= '0;
          q_reg   <= bus.dividend;
          dbz_reg <= 1'b0;
          busy_r  <= 1'b1;
          state   <= RUN;
        end else begin
          r_reg   <= {1'b0, bus.dividend};
          q_reg   <= DBZ_QUOTIENT[WIDTH-1:0];
          dbz_reg <= 1'b1;
          state   <= FIN;
        end
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_div_16_bit.sv
// Scoreboard bench for seq_div_16_bit: directed operations push their
// hand-computed results; a monitor pops and compares on every done pulse.
module tb_seq_div_16_bit;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];

  seq_div_16_bit_if #(.WIDTH(16)) bus ();

  seq_div_16_bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Done latency in clock edges after the accepting edge.
  localparam int LAT_DIV = 17;
  localparam int LAT_DBZ = 1;

  // Drive one start pulse; it is accepted on the next rising edge.
  task automatic issue(input logic [15:0] dd, input logic [15:0] ds,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edbz, input bit expect_it);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = ds;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (expect_it) begin
      e.q   = eq;
      e.r   = er;
      e.dbz = edbz;
      e.due = cyc + ((ds == 16'd0) ? LAT_DBZ : LAT_DIV);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    32'(bus.quotient),    32'(e.q));
        check("remainder",   32'(bus.remainder),   32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        check("latency",     32'(cyc),             32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy),        32'd0);
    check("rst_done", 32'(bus.done),        32'd0);
    check("rst_quot", 32'(bus.quotient),    32'd0);
    check("rst_rem",  32'(bus.remainder),   32'd0);
    check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100/7 with busy-length measurement
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    wait_drain();

    // Extremes
    issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    wait_drain();
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1'b1);
    wait_drain();
    issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b1);
    wait_drain();

    // Divide by zero, then a normal divide clears div_by_zero
    issue(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
    wait_drain();
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    wait_drain();

    // Start while busy is ignored
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    issue(16'd50, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
    wait_drain();

    // Back-to-back: second start lands in the FIN cycle
    issue(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    check("fin_busy", 32'(bus.busy), 32'd0);
    issue(16'd40, 16'd6, 16'd6, 16'd4, 1'b0, 1'b1);
    wait_drain();

    // Reset mid-operation aborts with no done pulse
    issue(16'd100, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(bus.busy),        32'd0);
    check("abort_done", 32'(bus.done),        32'd0);
    check("abort_quot", 32'(bus.quotient),    32'd0);
    check("abort_rem",  32'(bus.remainder),   32'd0);
    check("abort_dbz",  32'(bus.div_by_zero), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
